pb_sched: RTL and testbench

PB_SCHED -- requirements
Module: pb_sched

---
 rtl/pb_sched.sv | 219 +++++++++++++++++++++
 tb/tb_pb_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_sched.sv
// -----------------------------------------------------------------------------
// pb_sched
// Queues PB (packet-block) descriptors and launches them one at a time on an
// external enable generator. Each launch issues a one-cycle start pulse with
// the PB length, then tracks the generator read phase (gen_dout_vld) to
// decide when the PB is complete. A watchdog abandons a PB whose generator
// does not finish within TIMEOUT_CYC cycles.
//
// Parameters
//   FIFO_DEPTH   number of queued descriptors (power of two, 2..16)
//   TIMEOUT_CYC  watchdog limit in cycles for one PB
//
// Ports
//   clk           clock, all logic on the rising edge
//   n_rst         asynchronous active-low reset
//   req_vld       descriptor offered
//   req_type      PB type: 0 = PB16, 1 = PB136, 2 = PB520, 3 = reserved
//   req_rdy       descriptor accepted when req_vld && req_rdy
//   gen_start     one-cycle start pulse to the generator
//   gen_len       PB length to the generator, held until the next pop
//   gen_dout_vld  generator read-phase flag
//   busy          scheduler not idle
//   pb_done       one-cycle pulse when a PB completes normally
//   pb_cnt        completed PB count, wraps at 256
//   err_type      one-cycle pulse the cycle after a reserved type is taken
//   err_tout      one-cycle pulse when a PB is abandoned by the watchdog
//   fifo_lvl      number of queued descriptors
// -----------------------------------------------------------------------------
module pb_sched #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [11:0] TIMEOUT_CYC = 12'hFFF
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req_vld,
   input  logic [1:0]  req_type,
   output logic        req_rdy,
   output logic        gen_start,
   output logic [11:0] gen_len,
   input  logic        gen_dout_vld,
   output logic        busy,
   output logic        pb_done,
   output logic [7:0]  pb_cnt,
   output logic        err_type,
   output logic        err_tout,
   output logic [4:0]  fifo_lvl
);

   localparam int         AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] LP_FULL      = 5'(FIFO_DEPTH);
   localparam logic [1:0] LP_TYPE_RSVD = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_RD,
      S_READ,
      S_GAP
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [1:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [4:0]    r_lvl;
   logic [11:0]   r_len;
   logic [11:0]   r_wd;
   logic [7:0]    r_cnt;
   logic          r_done;
   logic          r_err_type;
   logic          r_err_tout;

   logic          w_hs;
   logic          w_push;
   logic          w_pop;
   logic          w_wd_hit;
   logic          w_done;
   logic          w_tout;

   // Length table for the stored (non-reserved) types.
   function automatic logic [11:0] f_type_len(input logic [1:0] t);
      case (t)
         2'd0:    f_type_len = 12'h040;
         2'd1:    f_type_len = 12'h220;
         default: f_type_len = 12'h820;
      endcase
   endfunction

   // Ready depends on the registered level only, so there is no
   // combinational path from req_vld back to req_rdy.
   assign req_rdy  = (r_lvl != LP_FULL);
   assign w_hs     = req_vld & req_rdy;
   // Reserved types complete the handshake but are never queued.
   assign w_push   = w_hs & (req_type != LP_TYPE_RSVD);
   // Popping happens exactly on the IDLE -> LAUNCH transition.
   assign w_pop    = (r_state == S_IDLE) & (r_lvl != 5'd0);
   assign w_wd_hit = (r_wd == TIMEOUT_CYC);

   // ---------------- descriptor storage (data, not reset) -----------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= req_type;
      end
   end

   // ---------------- FIFO pointers and level ------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_lvl    <= 5'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         // Simultaneous push and pop leave the level unchanged.
         case ({w_push, w_pop})
            2'b10:   r_lvl <= r_lvl + 5'd1;
            2'b01:   r_lvl <= r_lvl - 5'd1;
            default: r_lvl <= r_lvl;
         endcase
      end
   end

   // ---------------- FSM state register -----------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM next state ----------------------------------------
   // The watchdog check takes priority over the read-phase flag, so a PB
   // that hits the limit is reported as a timeout rather than a completion.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_tout      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_lvl != 5'd0) begin
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (w_wd_hit) begin
               w_state_nxt = S_GAP;
               w_tout      = 1'b1;
            end else if (gen_dout_vld) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (w_wd_hit) begin
               w_state_nxt = S_GAP;
               w_tout      = 1'b1;
            end else if (!gen_dout_vld) begin
               w_state_nxt = S_GAP;
               w_done      = 1'b1;
            end
         end
         S_GAP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------- length, watchdog, counters, pulses -------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_len      <= 12'd0;
         r_wd       <= 12'd0;
         r_cnt      <= 8'd0;
         r_done     <= 1'b0;
         r_err_type <= 1'b0;
         r_err_tout <= 1'b0;
      end else begin
         if (w_pop) begin
            r_len <= f_type_len(r_mem[r_rd_ptr]);
         end
         // Cleared on entry to LAUNCH, counts only while waiting on the
         // generator; its value outside those states is don't-care.
         if (w_pop) begin
            r_wd <= 12'd0;
         end else if ((r_state == S_WAIT_RD) || (r_state == S_READ)) begin
            r_wd <= r_wd + 12'd1;
         end
         if (w_done) begin
            r_cnt <= r_cnt + 8'd1;
         end
         r_done     <= w_done;
         r_err_type <= w_hs & (req_type == LP_TYPE_RSVD);
         r_err_tout <= w_tout;
      end
   end

   assign gen_start = (r_state == S_LAUNCH);
   assign gen_len   = r_len;
   assign busy      = (r_state != S_IDLE);
   assign pb_done   = r_done;
   assign pb_cnt    = r_cnt;
   assign err_type  = r_err_type;
   assign err_tout  = r_err_tout;
   assign fifo_lvl  = r_lvl;

endmodule

// File: tb/tb_pb_sched.sv
// -----------------------------------------------------------------------------
// tb_pb_sched
// Directed bench for pb_sched: a table of single-descriptor vectors followed
// by hand-written sequences for ordering, back-pressure, timeout, reset
// mid-PB and pb_cnt wrap. A generator model answers each gen_start by
// raising gen_dout_vld for gen_len cycles, or stays silent for one chosen
// launch. A monitor samples DUT outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_pb_sched;

   localparam int          DEPTH = 4;
   localparam logic [11:0] TOUT  = 12'hFFF;

   logic        clk;
   logic        n_rst;
   logic        req_vld;
   logic [1:0]  req_type;
   logic        req_rdy;
   logic        gen_start;
   logic [11:0] gen_len;
   logic        gen_dout_vld;
   logic        busy;
   logic        pb_done;
   logic [7:0]  pb_cnt;
   logic        err_type;
   logic        err_tout;
   logic [4:0]  fifo_lvl;

   pb_sched #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req_vld      (req_vld),
      .req_type     (req_type),
      .req_rdy      (req_rdy),
      .gen_start    (gen_start),
      .gen_len      (gen_len),
      .gen_dout_vld (gen_dout_vld),
      .busy         (busy),
      .pb_done      (pb_done),
      .pb_cnt       (pb_cnt),
      .err_type     (err_type),
      .err_tout     (err_tout),
      .fifo_lvl     (fifo_lvl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;

   // monitor state
   int          cyc;
   int          n_start;
   int          n_done;
   int          n_etype;
   int          n_etout;
   int          etype_cyc;
   int          tout_cyc;
   int          rdy_bad;
   int          lvl_over;
   int          start_cyc_q[$];
   logic [11:0] len_q[$];

   // generator model state
   int          gen_seen;
   int          silent_at;

   int          last_hs;

   typedef struct {
      logic [1:0]  typ;
      logic [11:0] exp_len;
      int          exp_start;
      int          exp_etype;
      int          exp_lvl1;
   } vec_t;

   vec_t vecs[4];

   // ---------------- monitor ----------------------------------------------
   initial begin
      cyc       = 0;
      n_start   = 0;
      n_done    = 0;
      n_etype   = 0;
      n_etout   = 0;
      etype_cyc = 0;
      tout_cyc  = 0;
      rdy_bad   = 0;
      lvl_over  = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (gen_start) begin
            n_start++;
            start_cyc_q.push_back(cyc);
            len_q.push_back(gen_len);
         end
         if (pb_done) n_done++;
         if (err_type) begin
            n_etype++;
            etype_cyc = cyc;
         end
         if (err_tout) begin
            n_etout++;
            tout_cyc = cyc;
         end
         if (fifo_lvl > 5'(DEPTH)) lvl_over++;
         if (req_rdy !== (fifo_lvl != 5'(DEPTH))) rdy_bad++;
      end
   end

   // ---------------- generator model ---------------------------------------
   initial begin
      int l;
      gen_dout_vld = 1'b0;
      gen_seen     = 0;
      forever begin
         @(negedge clk);
         if (gen_start && n_rst) begin
            gen_seen++;
            if (gen_seen != silent_at) begin
               l = int'(gen_len);
               @(negedge clk);
               gen_dout_vld = 1'b1;
               for (int k = 0; k < l; k++) begin
                  @(negedge clk);
                  if (!n_rst) break;
               end
               gen_dout_vld = 1'b0;
            end
         end
      end
   end

   // ---------------- helpers ----------------------------------------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] t);
      int guard;
      guard    = 0;
      req_vld  = 1'b1;
      req_type = t;
      while (!req_rdy && guard < 20000) begin
         tick();
         guard++;
      end
      if (guard >= 20000) check("push_rdy_wait", 32'(req_rdy), 32'd1);
      last_hs = cyc;
      tick();
      req_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      int quiet;
      guard = 0;
      quiet = 0;
      while (quiet < 3 && guard < 12000) begin
         tick();
         guard++;
         if (!busy && fifo_lvl == 5'd0) quiet++;
         else quiet = 0;
      end
      if (quiet < 3) check("wait_idle", 32'(quiet), 32'd3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     32'(busy),      32'd0);
      check({tag, "_req_rdy"},  32'(req_rdy),   32'd1);
      check({tag, "_fifo_lvl"}, 32'(fifo_lvl),  32'd0);
      check({tag, "_gen_start"},32'(gen_start), 32'd0);
      check({tag, "_gen_len"},  32'(gen_len),   32'd0);
      check({tag, "_pb_cnt"},   32'(pb_cnt),    32'd0);
      check({tag, "_pb_done"},  32'(pb_done),   32'd0);
      check({tag, "_err_type"}, 32'(err_type),  32'd0);
      check({tag, "_err_tout"}, 32'(err_tout),  32'd0);
   endtask

   // ---------------- global bound -----------------------------------------
   initial begin
      #(900_000);
      $display("FAIL global_timeout: run did not finish, tests=%0d", n_tests);
      $fatal(1, "global bound expired");
   end

   // ---------------- main sequence ----------------------------------------
   initial begin
      int b_start;
      int b_done;
      int b_etype;
      int b_tout;
      int b_len;
      int b_sq;
      int guard;
      int exp_cnt;
      int lat;
      logic [11:0] exp6 [6];

      vecs[0] = '{typ: 2'd0, exp_len: 12'h040, exp_start: 1, exp_etype: 0, exp_lvl1: 1};
      vecs[1] = '{typ: 2'd1, exp_len: 12'h220, exp_start: 1, exp_etype: 0, exp_lvl1: 1};
      vecs[2] = '{typ: 2'd2, exp_len: 12'h820, exp_start: 1, exp_etype: 0, exp_lvl1: 1};
      // reserved type: nothing queued, gen_len keeps the previous length
      vecs[3] = '{typ: 2'd3, exp_len: 12'h820, exp_start: 0, exp_etype: 1, exp_lvl1: 0};

      silent_at = -1;
      exp_cnt   = 0;
      req_vld   = 1'b0;
      req_type  = 2'd0;
      n_rst     = 1'b1;

      // reset state
      #2 n_rst = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");
      n_rst = 1'b1;
      repeat (2) tick();

      // table of single-descriptor vectors
      for (int i = 0; i < 4; i++) begin
         b_start = n_start;
         b_done  = n_done;
         b_etype = n_etype;
         b_tout  = n_etout;
         push(vecs[i].typ);
         check($sformatf("vec%0d_lvl_after_push", i), 32'(fifo_lvl), 32'(vecs[i].exp_lvl1));
         wait_idle();
         repeat (2) tick();
         if (vecs[i].exp_start != 0) exp_cnt = (exp_cnt + 1) % 256;
         check($sformatf("vec%0d_starts", i), 32'(n_start - b_start), 32'(vecs[i].exp_start));
         check($sformatf("vec%0d_done", i),   32'(n_done - b_done),   32'(vecs[i].exp_start));
         check($sformatf("vec%0d_etype", i),  32'(n_etype - b_etype), 32'(vecs[i].exp_etype));
         check($sformatf("vec%0d_etout", i),  32'(n_etout - b_tout),  32'd0);
         check($sformatf("vec%0d_gen_len", i), 32'(gen_len),          32'(vecs[i].exp_len));
         check($sformatf("vec%0d_pb_cnt", i),  32'(pb_cnt),           32'(exp_cnt));
         if (vecs[i].exp_start != 0) begin
            lat = start_cyc_q[$] - last_hs;
            check($sformatf("vec%0d_start_latency", i), 32'(lat), 32'd2);
         end
         if (vecs[i].exp_etype != 0) begin
            lat = etype_cyc - last_hs;
            check($sformatf("vec%0d_etype_latency", i), 32'(lat), 32'd1);
         end
      end

      // back-to-back types 1, 2, 0 complete in order
      b_done = n_done;
      b_len  = len_q.size();
      push(2'd1);
      push(2'd2);
      push(2'd0);
      wait_idle();
      exp_cnt = (exp_cnt + 3) % 256;
      check("b2b_done",  32'(n_done - b_done), 32'd3);
      check("b2b_len0",  32'(len_q[b_len]),     32'h220);
      check("b2b_len1",  32'(len_q[b_len + 1]), 32'h820);
      check("b2b_len2",  32'(len_q[b_len + 2]), 32'h040);
      check("b2b_pb_cnt", 32'(pb_cnt), 32'(exp_cnt));

      // reserved type immediately followed by a valid push: both take effect
      b_etype = n_etype;
      b_start = n_start;
      b_len   = len_q.size();
      push(2'd3);
      push(2'd0);
      wait_idle();
      exp_cnt = (exp_cnt + 1) % 256;
      check("rsvd_push_etype",  32'(n_etype - b_etype), 32'd1);
      check("rsvd_push_starts", 32'(n_start - b_start), 32'd1);
      check("rsvd_push_len",    32'(len_q[b_len]),      32'h040);
      check("rsvd_push_pb_cnt", 32'(pb_cnt),            32'(exp_cnt));

      // fill the FIFO while a PB runs, then one more push under back-pressure
      b_done  = n_done;
      b_start = n_start;
      b_len   = len_q.size();
      push(2'd0);
      guard = 0;
      while (n_start == b_start && guard < 10) begin
         tick();
         guard++;
      end
      check("full_first_launch", 32'(n_start - b_start), 32'd1);
      push(2'd1);
      push(2'd0);
      push(2'd1);
      push(2'd0);
      check("full_lvl", 32'(fifo_lvl), 32'd4);
      check("full_rdy", 32'(req_rdy),  32'd0);
      push(2'd0);
      wait_idle();
      exp_cnt = (exp_cnt + 6) % 256;
      exp6 = '{12'h040, 12'h220, 12'h040, 12'h220, 12'h040, 12'h040};
      check("full_done", 32'(n_done - b_done), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("full_order%0d", i), 32'(len_q[b_len + i]), 32'(exp6[i]));
      end
      check("full_pb_cnt", 32'(pb_cnt), 32'(exp_cnt));

      // silent generator: watchdog abandons the PB, the next one launches
      b_start = n_start;
      b_done  = n_done;
      b_tout  = n_etout;
      b_len   = len_q.size();
      b_sq    = start_cyc_q.size();
      silent_at = gen_seen + 1;
      push(2'd1);
      push(2'd0);
      wait_idle();
      exp_cnt = (exp_cnt + 1) % 256;
      check("tout_pulses", 32'(n_etout - b_tout),  32'd1);
      check("tout_done",   32'(n_done - b_done),   32'd1);
      check("tout_starts", 32'(n_start - b_start), 32'd2);
      // LAUNCH in cycle s; the watchdog is 0 in cycle s+1 and reaches the
      // limit in cycle s+1+TOUT; the registered pulse shows one cycle later.
      lat = tout_cyc - start_cyc_q[b_sq];
      check("tout_latency", 32'(lat), 32'(TOUT) + 32'd2);
      // GAP (pulse cycle), IDLE, then LAUNCH of the queued descriptor
      lat = start_cyc_q[b_sq + 1] - tout_cyc;
      check("tout_next_launch", 32'(lat), 32'd2);
      check("tout_len0",   32'(len_q[b_len]),     32'h220);
      check("tout_len1",   32'(len_q[b_len + 1]), 32'h040);
      check("tout_pb_cnt", 32'(pb_cnt), 32'(exp_cnt));

      // reset while reading with two descriptors queued
      b_start = n_start;
      push(2'd2);
      push(2'd0);
      push(2'd1);
      guard = 0;
      while (n_start == b_start && guard < 10) begin
         tick();
         guard++;
      end
      repeat (20) tick();
      check("mid_rst_busy_before", 32'(busy),     32'd1);
      check("mid_rst_lvl_before",  32'(fifo_lvl), 32'd2);
      n_rst = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      b_done  = n_done;
      b_start = n_start;
      repeat (3) tick();
      n_rst = 1'b1;
      repeat (100) tick();
      check("mid_rst_no_done",  32'(n_done - b_done),   32'd0);
      check("mid_rst_no_start", 32'(n_start - b_start), 32'd0);
      check("mid_rst_busy",     32'(busy),              32'd0);
      check("mid_rst_lvl",      32'(fifo_lvl),          32'd0);
      check("mid_rst_pb_cnt",   32'(pb_cnt),            32'd0);

      // pb_cnt wrap 255 -> 0 -> 1
      b_done = n_done;
      for (int i = 0; i < 255; i++) push(2'd0);
      wait_idle();
      check("wrap_255", 32'(pb_cnt), 32'd255);
      push(2'd0);
      push(2'd0);
      wait_idle();
      check("wrap_to_1",  32'(pb_cnt),          32'd1);
      check("wrap_done",  32'(n_done - b_done), 32'd257);

      // invariants watched by the monitor throughout the run
      check("rdy_vs_lvl", 32'(rdy_bad),  32'd0);
      check("lvl_bound",  32'(lvl_over), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
